// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg
// Shared types and constants for the AES-128 round controller.
//   state_e : controller FSM states
//   op_e    : round-operation select codes driven to the datapath
//   NUM_ROUNDS, RK_W, KEXP_W : round count and field widths
// Used by aes_round_ctrl and aes_kexp_timer.
package aes_ctrl_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int RK_W       = 4;
  localparam int KEXP_W     = 8;

  localparam logic [RK_W-1:0] LAST_ROUND = RK_W'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEXP,
    ST_INIT,
    ST_SUB,
    ST_SHIFT,
    ST_MIX,
    ST_ARK,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_SUB   = 2'd0,
    OP_SHIFT = 2'd1,
    OP_MIX   = 2'd2,
    OP_ARK   = 2'd3
  } op_e;

  // The timer is loaded with cycles-1 so that its zero flag is seen in the
  // last KEXP cycle, letting the FSM leave KEXP after exactly `cycles`
  // cycles. A zero request never enters KEXP, so its load value is unused.
  function automatic logic [KEXP_W-1:0] kexp_load_value(input int cycles);
    if (cycles == 0) begin
      return '0;
    end
    return KEXP_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/aes_kexp_timer.sv
// aes_kexp_timer
// 8-bit down-counter that times the key-expansion wait.
//   Clk      : system clock
//   Reset    : asynchronous, active-high; clears the count
//   load     : load load_val into the counter (has priority over en)
//   load_val : value to load
//   en       : decrement by one per cycle; holds at zero
//   zero     : high while the count is zero
module aes_kexp_timer
  import aes_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [KEXP_W-1:0] load_val,
  input  logic              en,
  output logic              zero
);

  logic [KEXP_W-1:0] count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Control FSM sequencing AES-128 over the shared 128-bit state register.
// Ports:
//   Clk, Reset : system clock; asynchronous active-high reset
//   start      : level request, sampled in IDLE and DONE
//   busy       : high in every state except IDLE and DONE
//   done       : high only in DONE
//   init_ld    : strobe for the register's message^rk0 initial load
//   state_ld   : strobe for the register's operation-result load
//   op_sel     : datapath op (0 SUB, 1 SHIFT, 2 MIX, 3 ARK)
//   rk_idx     : round-key index to the key schedule
//   decrypt    : (AES_CTRL_DECRYPT_EN only) direction, latched at start
//   inv        : (AES_CTRL_DECRYPT_EN only) latched decrypt
// Parameter KEXP_CYCLES (0..255) sets the key-expansion wait before INIT.
// Define AES_CTRL_DECRYPT_EN to add the inverse-cipher sequence.
// All outputs decode combinationally from registered state, so an
// asynchronous reset drops them immediately.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int KEXP_CYCLES = 10
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
`ifdef AES_CTRL_DECRYPT_EN
  input  logic            decrypt,
  output logic            inv,
`endif
  output logic            busy,
  output logic            done,
  output logic            init_ld,
  output logic            state_ld,
  output logic [1:0]      op_sel,
  output logic [RK_W-1:0] rk_idx
);

  localparam logic [KEXP_W-1:0] KEXP_LOAD = kexp_load_value(KEXP_CYCLES);
  localparam bit                KEXP_SKIP = (KEXP_CYCLES == 0);

  state_e          state_q;
  state_e          state_d;
  logic [RK_W-1:0] round_q;
  logic [RK_W-1:0] round_d;
  logic [RK_W-1:0] rk_round;
  logic            timer_load;
  logic            timer_en;
  logic            timer_zero;
  logic            dec_mode;
  op_e             op_cur;

  aes_kexp_timer u_kexp_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (timer_load),
    .load_val (KEXP_LOAD),
    .en       (timer_en),
    .zero     (timer_zero)
  );

`ifdef AES_CTRL_DECRYPT_EN
  logic dec_q;

  // Direction is captured on the accepting edge and held for the whole run,
  // so toggling decrypt while busy cannot corrupt a sequence.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dec_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      dec_q <= decrypt;
    end
  end

  assign dec_mode = dec_q;
  assign inv      = dec_q;
`else
  assign dec_mode = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state and round counter.
  // Encrypt rounds run SUB, SHIFT, MIX, ARK; the last round skips MIX and
  // the counter advances on ARK.
  // Decrypt rounds run SHIFT, SUB, ARK, MIX; the last round ends after ARK,
  // so the counter advances on MIX instead.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          timer_load = 1'b1;
          state_d    = KEXP_SKIP ? ST_INIT : ST_KEXP;
        end
      end

      ST_KEXP: begin
        timer_en = 1'b1;
        if (timer_zero) begin
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        round_d = RK_W'(1);
        state_d = dec_mode ? ST_SHIFT : ST_SUB;
      end

      ST_SUB: begin
        state_d = dec_mode ? ST_ARK : ST_SHIFT;
      end

      ST_SHIFT: begin
        if (dec_mode) begin
          state_d = ST_SUB;
        end else if (round_q == LAST_ROUND) begin
          state_d = ST_ARK;
        end else begin
          state_d = ST_MIX;
        end
      end

      ST_MIX: begin
        if (dec_mode) begin
          round_d = round_q + 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_ARK;
        end
      end

      ST_ARK: begin
        if (round_q == LAST_ROUND) begin
          state_d = ST_DONE;
        end else if (dec_mode) begin
          state_d = ST_MIX;
        end else begin
          round_d = round_q + 1'b1;
          state_d = ST_SUB;
        end
      end

      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decrypt walks the key schedule backwards: round r uses key 10-r.
  assign rk_round = dec_mode ? (LAST_ROUND - round_q) : round_q;

  // Output decode from the registered state.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    init_ld  = 1'b0;
    state_ld = 1'b0;
    op_cur   = OP_SUB;
    rk_idx   = '0;

    case (state_q)
      ST_KEXP: begin
        busy = 1'b1;
      end

      ST_INIT: begin
        busy    = 1'b1;
        init_ld = 1'b1;
        rk_idx  = dec_mode ? LAST_ROUND : '0;
      end

      ST_SUB: begin
        busy     = 1'b1;
        state_ld = 1'b1;
        op_cur   = OP_SUB;
        rk_idx   = rk_round;
      end

      ST_SHIFT: begin
        busy     = 1'b1;
        state_ld = 1'b1;
        op_cur   = OP_SHIFT;
        rk_idx   = rk_round;
      end

      ST_MIX: begin
        busy     = 1'b1;
        state_ld = 1'b1;
        op_cur   = OP_MIX;
        rk_idx   = rk_round;
      end

      ST_ARK: begin
        busy     = 1'b1;
        state_ld = 1'b1;
        op_cur   = OP_ARK;
        rk_idx   = rk_round;
      end

      ST_DONE: begin
        done = 1'b1;
      end

      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign op_sel = op_cur;

endmodule
